// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - writeback stage: MEM/WB register, write-back mux, halt FSM, retire counter
//
// Purpose: holds the MEM/WB pipeline register, selects the write-back value,
// resolves the destination register and drives the register-file write port.
// Also owns the RUN/HALTED state machine and the retired-instruction counter.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   stall, flush          hold the register / load a bubble (stall wins)
//   mem_*                 instruction fields arriving from the MEM stage
//   w_data, w_reg         register-file write data and destination
//   w_reg_cont            registered destination select, passed to decode
//   reg_w_en              register-file write enable
//   wb_valid              an instruction retires this cycle
//   halted                processor has halted
//   retired               retired-instruction count (wraps silently)

module wb_stage #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall,
   input  logic             flush,
   input  logic             mem_valid,
   input  logic [15:0]      mem_instruc,
   input  logic [15:0]      mem_alu_out,
   input  logic [15:0]      mem_rd_data,
   input  logic [15:0]      mem_seq_PC,
   input  logic [1:0]       mem_wb_sel,
   input  logic [1:0]       mem_w_reg_cont,
   input  logic             mem_reg_w_en,
   input  logic             mem_halt,
   output logic [15:0]      w_data,
   output logic [2:0]       w_reg,
   output logic [1:0]       w_reg_cont,
   output logic             reg_w_en,
   output logic             wb_valid,
   output logic             halted,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic {
      S_RUN    = 1'b0,
      S_HALTED = 1'b1
   } state_t;

   state_t     state_q, state_d;

   logic       valid_q,      valid_d;
   logic [15:0] instruc_q,   instruc_d;
   logic [15:0] alu_out_q,   alu_out_d;
   logic [15:0] rd_data_q,   rd_data_d;
   logic [15:0] seq_pc_q,    seq_pc_d;
   logic [1:0] wb_sel_q,     wb_sel_d;
   logic [1:0] w_reg_cont_q, w_reg_cont_d;
   logic       reg_w_en_q,   reg_w_en_d;
   logic       halt_q,       halt_d;
   logic [CNT_W-1:0] retired_q, retired_d;

   logic run;
   logic halt_retire;
   logic hold;

   assign run         = (state_q == S_RUN);
   // HALT leaving WB: the instruction behind it must not be captured.
   assign halt_retire = run & valid_q & halt_q & ~stall;
   assign hold        = ~run | stall | halt_retire;

   always_comb begin
      valid_d      = valid_q;
      instruc_d    = instruc_q;
      alu_out_d    = alu_out_q;
      rd_data_d    = rd_data_q;
      seq_pc_d     = seq_pc_q;
      wb_sel_d     = wb_sel_q;
      w_reg_cont_d = w_reg_cont_q;
      reg_w_en_d   = reg_w_en_q;
      halt_d       = halt_q;
      if (!hold) begin
         if (flush) begin
            valid_d      = 1'b0;
            instruc_d    = '0;
            alu_out_d    = '0;
            rd_data_d    = '0;
            seq_pc_d     = '0;
            wb_sel_d     = '0;
            w_reg_cont_d = '0;
            reg_w_en_d   = 1'b0;
            halt_d       = 1'b0;
         end else begin
            valid_d      = mem_valid;
            instruc_d    = mem_instruc;
            alu_out_d    = mem_alu_out;
            rd_data_d    = mem_rd_data;
            seq_pc_d     = mem_seq_PC;
            wb_sel_d     = mem_wb_sel;
            w_reg_cont_d = mem_w_reg_cont;
            reg_w_en_d   = mem_reg_w_en;
            halt_d       = mem_halt;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      retired_d = retired_q;
      if (halt_retire) begin
         state_d = S_HALTED;
      end
      if (wb_valid) begin
         retired_d = retired_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_RUN;
         retired_q    <= '0;
         valid_q      <= 1'b0;
         instruc_q    <= '0;
         alu_out_q    <= '0;
         rd_data_q    <= '0;
         seq_pc_q     <= '0;
         wb_sel_q     <= '0;
         w_reg_cont_q <= '0;
         reg_w_en_q   <= 1'b0;
         halt_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         retired_q    <= retired_d;
         valid_q      <= valid_d;
         instruc_q    <= instruc_d;
         alu_out_q    <= alu_out_d;
         rd_data_q    <= rd_data_d;
         seq_pc_q     <= seq_pc_d;
         wb_sel_q     <= wb_sel_d;
         w_reg_cont_q <= w_reg_cont_d;
         reg_w_en_q   <= reg_w_en_d;
         halt_q       <= halt_d;
      end
   end

   // Write-back source; the reserved encoding falls back to the ALU result.
   always_comb begin
      case (wb_sel_q)
         2'b01:   w_data = rd_data_q;
         2'b10:   w_data = seq_pc_q;
         default: w_data = alu_out_q;
      endcase
   end

   always_comb begin
      case (w_reg_cont_q)
         2'b00:   w_reg = instruc_q[4:2];
         2'b01:   w_reg = instruc_q[7:5];
         2'b10:   w_reg = instruc_q[10:8];
         default: w_reg = 3'd7;
      endcase
   end

   assign w_reg_cont = w_reg_cont_q;
   // Deliberately not gated by stall: the register file may rewrite the same value.
   assign reg_w_en   = valid_q & reg_w_en_q & ~halt_q & run;
   assign wb_valid   = valid_q & ~stall & run;
   assign halted     = ~run;
   assign retired    = retired_q;

endmodule
